// File: rtl/feng_ctl_pkg.sv
// feng_ctl_pkg: shared state encoding and control-word bit positions for the F-engine sequencer
package feng_ctl_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DELAY = 2'd2,
        FIRE  = 2'd3
    } state_t;
    localparam int ARM_BIT       = 0;
    localparam int SOFT_SYNC_BIT = 1;
    localparam int CLR_BIT       = 2;
    localparam int DISARM_BIT    = 3;
    localparam int OFFSET_LSB    = 16;
endpackage

// File: rtl/feng_ctl_sequencer_edge_det.sv
// edge_det: per-bit rising-edge detector with a history register that resets high
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset
//   i_d    : monitored bits
//   o_rise : high for bits that are 1 now and were 0 last cycle
module edge_det #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_rise
);
    logic [W-1:0] r_prev;
    // History resets to all ones so levels already high at reset release produce no edge
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) r_prev <= '1;
        else       r_prev <= i_d;
    assign o_rise = i_d & ~r_prev;
endmodule

// File: rtl/feng_ctl_sequencer.sv
// feng_ctl_sequencer: turns control-word commands and the external sync strobe into a delayed one-cycle sync pulse
//   user_clk   : sole clock
//   user_rst   : asynchronous active-high reset
//   ctl_word   : [0] arm, [1] soft_sync, [2] clr, [3] disarm, [31:16] sync offset
//   sync_in    : external sync strobe, any pulse width
//   sync_out   : one-cycle sync pulse to the datapath
//   armed      : high while waiting for sync or counting the offset
//   clr_pulse  : one-cycle status-clear strobe
//   sync_count : sync pulses since the last clear
//   state_out  : current FSM state
module feng_ctl_sequencer
    import feng_ctl_pkg::*;
#(
    parameter int OFFSET_WIDTH = 16
) (
    input  logic        user_clk,
    input  logic        user_rst,
    input  logic [31:0] ctl_word,
    input  logic        sync_in,
    output logic        sync_out,
    output logic        armed,
    output logic        clr_pulse,
    output logic [31:0] sync_count,
    output logic [1:0]  state_out
);
    logic [DISARM_BIT+1:0]   w_rise;
    logic                    w_arm, w_soft, w_clr, w_disarm, w_sync, w_fire, w_unused;
    logic [OFFSET_WIDTH-1:0] w_offset, w_cnt, r_cnt;
    state_t                  w_next, r_state;
    logic                    r_soft, r_sync_out, r_armed, r_clr_pulse;
    logic [31:0]             r_sync_count;

    edge_det #(.W(DISARM_BIT + 2)) u_edge_det (
        .i_clk  (user_clk),
        .i_rst  (user_rst),
        .i_d    ({sync_in, ctl_word[DISARM_BIT:ARM_BIT]}),
        .o_rise (w_rise)
    );

    assign w_arm    = w_rise[ARM_BIT];
    assign w_soft   = w_rise[SOFT_SYNC_BIT];
    assign w_clr    = w_rise[CLR_BIT];
    assign w_disarm = w_rise[DISARM_BIT];
    assign w_sync   = w_rise[DISARM_BIT+1];
    assign w_offset = ctl_word[OFFSET_LSB +: OFFSET_WIDTH];
    assign w_unused = ^ctl_word[OFFSET_LSB-1:DISARM_BIT+1];

    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        case (r_state)
            IDLE: w_next = w_soft ? FIRE : w_arm ? ARMED : IDLE;
            ARMED: begin
                w_cnt  = w_sync ? w_offset : r_cnt;
                w_next = w_disarm ? IDLE : !w_sync ? ARMED : (w_offset == '0) ? FIRE : DELAY;
            end
            DELAY: begin
                w_cnt  = r_cnt - OFFSET_WIDTH'(1);
                w_next = w_disarm ? IDLE : (r_cnt == OFFSET_WIDTH'(1)) ? FIRE : DELAY;
            end
            default: w_next = IDLE;
        endcase
    end

    // Hardware-sync FIRE carries the pulse on entry; soft-sync FIRE is entered
    // from IDLE and emits its pulse as it leaves, one cycle later
    assign w_fire = (r_state == FIRE) ? r_soft : (r_state != IDLE && w_next == FIRE);

    always_ff @(posedge user_clk or posedge user_rst)
        if (user_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_soft       <= 1'b0;
            r_sync_out   <= 1'b0;
            r_armed      <= 1'b0;
            r_clr_pulse  <= 1'b0;
            r_sync_count <= '0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt;
            r_soft       <= (r_state == IDLE) && w_soft;
            r_sync_out   <= w_fire;
            r_armed      <= (w_next == ARMED) || (w_next == DELAY);
            r_clr_pulse  <= w_clr;
            r_sync_count <= w_clr ? '0 : r_sync_count + 32'(w_fire);
        end

    assign sync_out   = r_sync_out;
    assign armed      = r_armed;
    assign clr_pulse  = r_clr_pulse;
    assign sync_count = r_sync_count;
    assign state_out  = r_state;
endmodule

// File: tb/tb_feng_ctl_sequencer.sv
// tb_feng_ctl_sequencer: directed and randomized checks of the sync sequencer against a timestamp-based model
module tb_feng_ctl_sequencer;
    logic        user_clk = 1'b0;
    logic        user_rst;
    logic [31:0] ctl_word = '0;
    logic        sync_in = 1'b0;
    logic        sync_out, armed, clr_pulse;
    logic [31:0] sync_count;
    logic [1:0]  state_out;

    int errors = 0;
    int checks = 0;

    // Model: absolute cycle numbers instead of a counter
    int          cyc;
    int          fire_at;
    int          idle_from;
    bit          waiting;
    bit          hard;
    logic [31:0] m_count;
    logic [3:0]  pctl;
    logic        psin;
    logic        exp_clr;

    feng_ctl_sequencer #(.OFFSET_WIDTH(16)) dut (
        .user_clk   (user_clk),
        .user_rst   (user_rst),
        .ctl_word   (ctl_word),
        .sync_in    (sync_in),
        .sync_out   (sync_out),
        .armed      (armed),
        .clr_pulse  (clr_pulse),
        .sync_count (sync_count),
        .state_out  (state_out)
    );

    always #5 user_clk = ~user_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cycle %0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        fire_at   = -1;
        idle_from = cyc;
        waiting   = 1'b0;
        hard      = 1'b0;
        m_count   = '0;
        pctl      = '1;
        psin      = 1'b1;
        exp_clr   = 1'b0;
    endtask

    // Apply the rules to the inputs seen during cycle cyc, giving expectations for cyc+1
    task automatic model_update();
        logic [3:0] e;
        bit         sync_e, idle_n, delaying;
        e        = ctl_word[3:0] & ~pctl;
        sync_e   = sync_in & ~psin;
        idle_n   = !waiting && cyc >= idle_from;
        delaying = !waiting && hard && fire_at > cyc;
        if (idle_n) begin
            if (e[1]) begin
                fire_at   = cyc + 2;
                idle_from = cyc + 2;
                hard      = 1'b0;
            end else if (e[0]) waiting = 1'b1;
        end else if (waiting) begin
            if (e[3]) waiting = 1'b0;
            else if (sync_e) begin
                waiting   = 1'b0;
                hard      = 1'b1;
                fire_at   = cyc + 1 + int'(ctl_word[31:16]);
                idle_from = fire_at + 1;
            end
        end else if (delaying && e[3]) begin
            fire_at   = -1;
            hard      = 1'b0;
            idle_from = cyc + 1;
        end
        exp_clr = e[2];
        if (e[2]) m_count = '0;
        else if (fire_at == cyc + 1) m_count = m_count + 1;
        pctl = ctl_word[3:0];
        psin = sync_in;
    endtask

    task automatic step();
        logic [1:0] exp_state;
        model_update();
        @(posedge user_clk);
        #1;
        cyc++;
        exp_state = waiting ? 2'd1 : (hard && fire_at > cyc) ? 2'd2 : (cyc < idle_from) ? 2'd3 : 2'd0;
        chk("sync_out",   32'(sync_out),  32'(fire_at == cyc));
        chk("armed",      32'(armed),     32'(waiting || (hard && fire_at > cyc)));
        chk("clr_pulse",  32'(clr_pulse), 32'(exp_clr));
        chk("sync_count", sync_count,     m_count);
        chk("state_out",  32'(state_out), 32'(exp_state));
    endtask

    task automatic drive(input logic [31:0] c, input logic s);
        ctl_word = c;
        sync_in  = s;
        step();
    endtask

    task automatic do_reset(input logic [31:0] c);
        ctl_word = c;
        sync_in  = 1'b0;
        user_rst = 1'b1;
        #1;
        chk("rst_sync_out",   32'(sync_out),  32'd0);
        chk("rst_armed",      32'(armed),     32'd0);
        chk("rst_clr_pulse",  32'(clr_pulse), 32'd0);
        chk("rst_sync_count", sync_count,     32'd0);
        chk("rst_state",      32'(state_out), 32'd0);
        repeat (2) @(posedge user_clk);
        @(negedge user_clk);
        user_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int base;
        cyc = 0;
        do_reset(32'h0);
        repeat (3) step();

        // Arm, offset 5, sync 10 cycles after the arm edge
        base = cyc;
        drive(32'h0005_0001, 1'b0);
        repeat (9) step();
        drive(32'h0005_0001, 1'b1);
        drive(32'h0005_0001, 1'b1);
        drive(32'h0005_0001, 1'b0);
        while (cyc < base + 16) step();
        chk("arm_sync_fire",  32'(sync_out), 32'd1);
        chk("arm_armed_low",  32'(armed),    32'd0);
        chk("arm_sync_count", sync_count,    32'd1);
        repeat (4) step();

        // Soft sync, then the bit held high
        drive(32'h0, 1'b0);
        drive(32'h2, 1'b0);
        step();
        chk("soft_fire",  32'(sync_out), 32'd1);
        chk("soft_count", sync_count,    32'd2);
        repeat (6) drive(32'h2, 1'b0);

        // Disarm 20 cycles into a 100-cycle delay
        drive(32'h0, 1'b0);
        drive(32'h0064_0001, 1'b0);
        drive(32'h0064_0001, 1'b1);
        ctl_word = 32'h0064_0001;
        sync_in  = 1'b0;
        repeat (19) step();
        drive(32'h0064_0009, 1'b0);
        chk("disarm_state", 32'(state_out), 32'd0);
        repeat (100) step();
        chk("disarm_count", sync_count, 32'd2);

        // Clear edge landing on the FIRE increment
        drive(32'h0, 1'b0);
        drive(32'h0003_0001, 1'b0);
        drive(32'h0003_0001, 1'b1);
        drive(32'h0003_0001, 1'b0);
        step();
        drive(32'h0003_0005, 1'b0);
        chk("clr_fire",  32'(sync_out),  32'd1);
        chk("clr_pulse", 32'(clr_pulse), 32'd1);
        chk("clr_count", sync_count,     32'd0);
        repeat (3) step();

        // Counter wrap
        drive(32'h0, 1'b0);
        force dut.r_sync_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_sync_count;
        m_count = 32'hFFFF_FFFF;
        step();
        chk("wrap_preload", sync_count, 32'hFFFF_FFFF);
        drive(32'h2, 1'b0);
        step();
        chk("wrap_count", sync_count, 32'h0);
        repeat (3) step();

        // Randomized commands, offsets and sync strobes
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0)
                ctl_word = {16'($urandom_range(6)), 12'($urandom), 4'($urandom)};
            if ($urandom_range(4) == 0) sync_in = ~sync_in;
            step();
        end

        // Arm bit held high across reset release
        do_reset(32'h1);
        repeat (5) step();
        chk("rst_held_idle", 32'(state_out), 32'd0);

        // Reset in the middle of a delay
        drive(32'h0, 1'b0);
        drive(32'h000A_0001, 1'b0);
        drive(32'h000A_0001, 1'b1);
        ctl_word = 32'h000A_0001;
        sync_in  = 1'b0;
        repeat (3) step();
        chk("mid_delay_state", 32'(state_out), 32'd2);
        do_reset(32'h000A_0001);
        repeat (20) step();
        chk("abort_state", 32'(state_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
